// File: rtl/kore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kore_pkg
// Description : Shared definitions for the kore issue path. Holds the opcode
//               classes the sequencer understands, the functional-unit select
//               encodings and the issue-controller state encoding.
// Contents    : OP_* opcodes, FU_* unit selects, state_t
// Revision    : 1.0 - initial release
// ============================================================================
package kore_pkg;

  // Major opcodes (ir_code[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Functional-unit select
  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_MEM  = 2'd1;
  localparam logic [1:0] FU_BR   = 2'd2;
  localparam logic [1:0] FU_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RETIRE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/kore_dec_class.sv
`default_nettype none
// ============================================================================
// Module      : kore_dec_class
// Description : Combinational opcode classifier. Maps an opcode/funct3 pair
//               to the functional unit that executes it, or flags it illegal.
// Ports       : i_opcode  [6:0] instruction opcode
//               i_funct3  [2:0] instruction funct3
//               o_fu_sel  [1:0] selected unit (FU_NONE when illegal)
//               o_illegal       opcode/funct3 combination not supported
// Revision    : 1.0 - initial release
// ============================================================================
module kore_dec_class
  import kore_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [1:0] o_fu_sel,
  output logic       o_illegal
);

  always_comb begin
    o_fu_sel  = FU_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R, OP_I:        o_fu_sel = FU_ALU;
      OP_LOAD, OP_STORE: o_fu_sel = FU_MEM;
      OP_BRANCH: begin
        // funct3 010/011 are unassigned branch encodings
        if ((i_funct3 == 3'b010) || (i_funct3 == 3'b011)) begin
          o_illegal = 1'b1;
        end else begin
          o_fu_sel = FU_BR;
        end
      end
      OP_JAL, OP_JALR:   o_fu_sel = FU_BR;
      default:           o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/kore_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kore_issue_ctrl
// Description : Single-issue sequencer. Accepts one instruction from the IR
//               stage, decodes its class, starts exactly one functional-unit
//               FSM, waits for end-of-operation (bounded by TIMEOUT) and
//               retires it, redirecting the PC for taken branches/jumps.
// Ports       : clk, rst_n (async, active-low)
//               i_ir_vld/o_ir_rdy, i_ir_code, i_pc_in  - IR handshake
//               o_fu_sel, o_fu_start                    - unit issue
//               o_opcode, o_funct3, o_pcdata_rs0/rs1/rd, o_pc_cur - fields
//               i_eop, i_br_taken, i_br_target          - unit completion
//               o_redir_vld, o_redir_pc                 - PC redirect
//               o_retire, o_ill_insn, o_timeout_err     - status pulses
//               o_opflag                                - busy flag
// Revision    : 1.0 - initial release
// ============================================================================
module kore_issue_ctrl
  import kore_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_ir_vld,
  output logic            o_ir_rdy,
  input  logic [XLEN-1:0] i_ir_code,
  input  logic [XLEN-1:0] i_pc_in,
  output logic [1:0]      o_fu_sel,
  output logic            o_fu_start,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_pcdata_rs0,
  output logic [4:0]      o_pcdata_rs1,
  output logic [4:0]      o_pcdata_rd,
  output logic [XLEN-1:0] o_pc_cur,
  input  logic            i_eop,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_target,
  output logic            o_redir_vld,
  output logic [XLEN-1:0] o_redir_pc,
  output logic            o_retire,
  output logic            o_ill_insn,
  output logic            o_timeout_err,
  output logic            o_opflag
);

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  state_t          r_state;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rs0;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pc_cur;
  logic [1:0]      r_fu_sel;
  logic            r_fu_start;
  logic [7:0]      r_wait_cnt;
  logic            r_redir_vld;
  logic [XLEN-1:0] r_redir_pc;
  logic            r_retire;
  logic            r_ill_insn;
  logic            r_timeout_err;

  logic [1:0]      w_dec_sel;
  logic            w_dec_ill;
  // funct7 and upper immediate bits are consumed by the functional units,
  // not by the sequencer
  logic            w_unused_hi;

  assign w_unused_hi = ^i_ir_code[XLEN-1:25];

  kore_dec_class u_dec_class (
    .i_opcode  (r_opcode),
    .i_funct3  (r_funct3),
    .o_fu_sel  (w_dec_sel),
    .o_illegal (w_dec_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_opcode      <= '0;
      r_funct3      <= '0;
      r_rs0         <= '0;
      r_rs1         <= '0;
      r_rd          <= '0;
      r_pc_cur      <= '0;
      r_fu_sel      <= FU_NONE;
      r_fu_start    <= 1'b0;
      r_wait_cnt    <= '0;
      r_redir_vld   <= 1'b0;
      r_redir_pc    <= '0;
      r_retire      <= 1'b0;
      r_ill_insn    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Every status output is a single-cycle pulse
      r_fu_start    <= 1'b0;
      r_redir_vld   <= 1'b0;
      r_retire      <= 1'b0;
      r_ill_insn    <= 1'b0;
      r_timeout_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_ir_vld) begin
            r_opcode <= i_ir_code[6:0];
            r_rd     <= i_ir_code[11:7];
            r_funct3 <= i_ir_code[14:12];
            r_rs0    <= i_ir_code[19:15];
            r_rs1    <= i_ir_code[24:20];
            r_pc_cur <= i_pc_in;
            r_state  <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (w_dec_ill) begin
            r_ill_insn <= 1'b1;
            r_fu_sel   <= FU_NONE;
            r_state    <= ST_IDLE;
          end else begin
            // Start pulse is registered here so it is visible during ISSUE
            r_fu_sel   <= w_dec_sel;
            r_fu_start <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end

        ST_WAIT: begin
          // eop takes priority over a timeout expiring in the same cycle
          if (i_eop) begin
            r_retire <= 1'b1;
            if ((r_fu_sel == FU_BR) && i_br_taken) begin
              r_redir_vld <= 1'b1;
              r_redir_pc  <= i_br_target;
            end
            r_state <= ST_RETIRE;
          end else if (r_wait_cnt == c_TIMEOUT) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        ST_RETIRE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ir_rdy      = (r_state == ST_IDLE);
  assign o_opflag      = (r_state != ST_IDLE);
  assign o_fu_sel      = r_fu_sel;
  assign o_fu_start    = r_fu_start;
  assign o_opcode      = r_opcode;
  assign o_funct3      = r_funct3;
  assign o_pcdata_rs0  = r_rs0;
  assign o_pcdata_rs1  = r_rs1;
  assign o_pcdata_rd   = r_rd;
  assign o_pc_cur      = r_pc_cur;
  assign o_redir_vld   = r_redir_vld;
  assign o_redir_pc    = r_redir_pc;
  assign o_retire      = r_retire;
  assign o_ill_insn    = r_ill_insn;
  assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_kore_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kore_issue_ctrl
// Description : Self-checking bench for kore_issue_ctrl. A table of directed
//               instructions with hand-computed fields and outcomes is run
//               through a cycle-exact transaction task, followed by reset
//               and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kore_issue_ctrl;

  localparam int c_TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ir_vld;
  logic        ir_rdy;
  logic [31:0] ir_code;
  logic [31:0] pc_in;
  logic [1:0]  fu_sel;
  logic        fu_start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs0, rs1, rd;
  logic [31:0] pc_cur;
  logic        eop;
  logic        br_taken;
  logic [31:0] br_target;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic        retire;
  logic        ill_insn;
  logic        timeout_err;
  logic        opflag;

  int checks   = 0;
  int failures = 0;

  kore_issue_ctrl #(.XLEN(32), .TIMEOUT(c_TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ir_vld      (ir_vld),
    .o_ir_rdy      (ir_rdy),
    .i_ir_code     (ir_code),
    .i_pc_in       (pc_in),
    .o_fu_sel      (fu_sel),
    .o_fu_start    (fu_start),
    .o_opcode      (opcode),
    .o_funct3      (funct3),
    .o_pcdata_rs0  (rs0),
    .o_pcdata_rs1  (rs1),
    .o_pcdata_rd   (rd),
    .o_pc_cur      (pc_cur),
    .i_eop         (eop),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .o_redir_vld   (redir_vld),
    .o_redir_pc    (redir_pc),
    .o_retire      (retire),
    .o_ill_insn    (ill_insn),
    .o_timeout_err (timeout_err),
    .o_opflag      (opflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    int          eop_at;   // WAIT cycle index carrying eop, -1 = never
    logic        early;    // also drive eop during IDLE/DECODE/ISSUE
    logic        taken;
    logic [31:0] target;
    logic [1:0]  sel;
    logic        ill;
    logic        redir;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [4:0]  rd;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after an edge with the DUT idle (cycle 0).
  task automatic run(input vec_t v);
    logic done;
    done = 1'b0;
    chk("rdy_idle", ir_rdy, 1);
    ir_vld = 1'b1; ir_code = v.code; pc_in = v.pc;
    eop = v.early; br_taken = v.taken; br_target = v.target;
    step();  // cycle 1: DECODE
    ir_vld = 1'b0; ir_code = 32'hDEAD_BEEF; pc_in = 32'hFFFF_FFF0;
    chk("opflag_dec", opflag, 1);
    chk("rdy_dec", ir_rdy, 0);
    chk("opcode", opcode, v.op);
    chk("funct3", funct3, v.f3);
    chk("rs0", rs0, v.rs0);
    chk("rs1", rs1, v.rs1);
    chk("rd", rd, v.rd);
    chk("pc_cur", pc_cur, v.pc);
    chk("start_dec", fu_start, 0);
    step();  // cycle 2: ISSUE, or IDLE after an illegal decode
    if (v.ill) begin
      eop = 1'b0;
      chk("ill_pulse", ill_insn, 1);
      chk("ill_nostart", fu_start, 0);
      chk("ill_rdy", ir_rdy, 1);
      chk("ill_sel", fu_sel, 3);
      step();
      chk("ill_clear", ill_insn, 0);
    end else begin
      chk("start", fu_start, 1);
      chk("sel", fu_sel, v.sel);
      chk("noill", ill_insn, 0);
      step();  // cycle 3: first WAIT cycle
      for (int j = 0; j <= c_TO; j++) begin
        if (!done) begin
          eop = (v.eop_at == j);
          chk("start_once", fu_start, 0);
          step();
          eop = 1'b0;
          if (v.eop_at == j) begin
            done = 1'b1;
            chk("retire", retire, 1);
            chk("redir_vld", redir_vld, v.redir);
            if (v.redir) chk("redir_pc", redir_pc, v.target);
            chk("no_to_ret", timeout_err, 0);
            step();
            chk("retire_clr", retire, 0);
            chk("redir_clr", redir_vld, 0);
            chk("rdy_after", ir_rdy, 1);
            chk("opflag_after", opflag, 0);
          end else if (j < c_TO) begin
            chk("wait_noret", retire, 0);
            chk("wait_noto", timeout_err, 0);
            chk("wait_busy", opflag, 1);
          end else begin
            chk("timeout", timeout_err, 1);
            chk("to_noret", retire, 0);
            chk("to_rdy", ir_rdy, 1);
            step();
            chk("to_clear", timeout_err, 0);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ret, starts, bad;
    vec_t add_v;

    // code, pc, eop_at, early, taken, target, sel, ill, redir, op, f3, rs0, rs1, rd
    tbl[0]  = '{32'h002081B3, 32'h100, 0, 1'b0, 1'b0, 32'h0,   2'd0, 1'b0, 1'b0, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3};
    tbl[1]  = '{32'h00208463, 32'h200, 0, 1'b0, 1'b1, 32'h208, 2'd2, 1'b0, 1'b1, 7'h63, 3'd0, 5'd1, 5'd2, 5'd8};
    tbl[2]  = '{32'h00208463, 32'h200, 2, 1'b0, 1'b0, 32'h208, 2'd2, 1'b0, 1'b0, 7'h63, 3'd0, 5'd1, 5'd2, 5'd8};
    tbl[3]  = '{32'h0000007F, 32'h300, 0, 1'b0, 1'b0, 32'h0,   2'd3, 1'b1, 1'b0, 7'h7F, 3'd0, 5'd0, 5'd0, 5'd0};
    tbl[4]  = '{32'h00002063, 32'h304, 0, 1'b0, 1'b0, 32'h0,   2'd3, 1'b1, 1'b0, 7'h63, 3'd2, 5'd0, 5'd0, 5'd0};
    tbl[5]  = '{32'h00003063, 32'h308, 0, 1'b0, 1'b0, 32'h0,   2'd3, 1'b1, 1'b0, 7'h63, 3'd3, 5'd0, 5'd0, 5'd0};
    tbl[6]  = '{32'h0000A283, 32'h400, -1, 1'b0, 1'b0, 32'h0,  2'd1, 1'b0, 1'b0, 7'h03, 3'd2, 5'd1, 5'd0, 5'd5};
    tbl[7]  = '{32'h0020A223, 32'h404, 4, 1'b1, 1'b1, 32'h999, 2'd1, 1'b0, 1'b0, 7'h23, 3'd2, 5'd1, 5'd2, 5'd4};
    tbl[8]  = '{32'h00500093, 32'h408, 1, 1'b0, 1'b1, 32'h777, 2'd0, 1'b0, 1'b0, 7'h13, 3'd0, 5'd0, 5'd5, 5'd1};
    tbl[9]  = '{32'h008000EF, 32'h500, 3, 1'b0, 1'b1, 32'h400, 2'd2, 1'b0, 1'b1, 7'h6F, 3'd0, 5'd0, 5'd8, 5'd1};
    tbl[10] = '{32'h00008067, 32'h404, 0, 1'b1, 1'b1, 32'h304, 2'd2, 1'b0, 1'b1, 7'h67, 3'd0, 5'd1, 5'd0, 5'd0};
    tbl[11] = '{32'h00000537, 32'h600, 0, 1'b0, 1'b0, 32'h0,   2'd3, 1'b1, 1'b0, 7'h37, 3'd0, 5'd0, 5'd0, 5'd10};
    tbl[12] = '{32'h00004063, 32'h604, 0, 1'b0, 1'b0, 32'h0,   2'd2, 1'b0, 1'b0, 7'h63, 3'd4, 5'd0, 5'd0, 5'd0};
    add_v = tbl[0];

    rst_n = 1'b0; ir_vld = 1'b0; ir_code = '0; pc_in = '0;
    eop = 1'b0; br_taken = 1'b0; br_target = '0;
    step(); step();
    chk("rst_rdy", ir_rdy, 1);
    chk("rst_opflag", opflag, 0);
    chk("rst_sel", fu_sel, 3);
    chk("rst_start", fu_start, 0);
    chk("rst_retire", retire, 0);
    chk("rst_redir", redir_vld, 0);
    chk("rst_ill", ill_insn, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_pc", pc_cur, 0);
    chk("rst_rpc", redir_pc, 0);
    chk("rst_opcode", opcode, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) run(tbl[i]);

    // Asynchronous reset while in WAIT
    ir_vld = 1'b1; ir_code = add_v.code; pc_in = add_v.pc;
    step();
    ir_vld = 1'b0;
    step(); step();
    chk("mid_busy", opflag, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rdy", ir_rdy, 1);
    chk("mid_opflag", opflag, 0);
    chk("mid_sel", fu_sel, 3);
    chk("mid_pc", pc_cur, 0);
    chk("mid_rd", rd, 0);
    chk("mid_rpc", redir_pc, 0);
    chk("mid_start", fu_start, 0);
    step();
    rst_n = 1'b1;
    step();
    run(add_v);

    // Back-to-back with ir_vld held high and eop always asserted
    acc = 0; ret = 0; starts = 0; bad = 0;
    ir_vld = 1'b1; ir_code = add_v.code; pc_in = add_v.pc; eop = 1'b1; br_taken = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ir_rdy) acc++;
      if (retire) ret++;
      if (fu_start) starts++;
      if (ir_rdy === opflag) bad++;
      step();
    end
    ir_vld = 1'b0; eop = 1'b0;
    chk("b2b_accepts", acc, 4);
    chk("b2b_retires", ret, 4);
    chk("b2b_starts", starts, 4);
    chk("b2b_rdy_busy", bad, 0);
    step();
    chk("b2b_idle", ir_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kore_issue_ctrl.md
# kore_issue_ctrl

Single-issue instruction sequencer for the kore core. Accepts one instruction word plus its PC from the IR stage over a valid/ready handshake, then decodes the opcode class and field slices. It starts exactly one functional-unit FSM (ALU, MEM or BR), waits for that unit's end-of-operation, and retires the instruction, issuing a PC redirect for taken branches and jumps. It sits between the IR register and the function FSMs and owns the op-busy flag.

## Interface
Parameters:
- XLEN, 32, instruction/PC width
- TIMEOUT, 255, max WAIT cycles before abort (8-bit counter; legal range 1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ir_vld  in  1  instruction word valid
- ir_rdy  out  1  controller can accept an instruction
- ir_code  in  XLEN  instruction word
- pc_in  in  XLEN  PC of ir_code
- fu_sel  out  2  0=ALU, 1=MEM, 2=BR, 3=none
- fu_start  out  1  one-cycle start pulse to the selected unit
- opcode  out  7  latched ir_code[6:0]
- funct3  out  3  latched ir_code[14:12]
- pcdata_rs0  out  5  latched ir_code[19:15]
- pcdata_rs1  out  5  latched ir_code[24:20]
- pcdata_rd  out  5  latched ir_code[11:7]
- pc_cur  out  XLEN  latched PC
- eop  in  1  end of operation from the selected function FSM
- br_taken  in  1  taken flag, sampled with eop
- br_target  in  XLEN  redirect target, sampled with eop
- redir_vld  out  1  one-cycle redirect pulse
- redir_pc  out  XLEN  redirect address
- retire  out  1  one-cycle retire pulse
- ill_insn  out  1  one-cycle illegal-instruction pulse
- timeout_err  out  1  one-cycle FU timeout pulse
- opflag  out  1  busy: high whenever state is not IDLE

## Operation
- States: IDLE, DECODE, ISSUE, WAIT, RETIRE.
- IDLE: ir_rdy=1. On ir_vld, latch ir_code and pc_in, then go to DECODE.
- DECODE: classify the latched opcode.
  - 0110011 or 0010011 → ALU.
  - 0000011 or 0100011 → MEM.
  - 1100011, 1101111 or 1100111 → BR.
  - A branch (1100011) with funct3 010 or 011 is illegal.
  - Any other opcode is illegal.
  - Illegal: pulse ill_insn, set fu_sel=3, go to IDLE.
  - Legal: register fu_sel, go to ISSUE.
- ISSUE: fu_start=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT: the counter increments each cycle.
  - eop=1: capture br_taken and br_target, go to RETIRE.
  - Counter reaches TIMEOUT without eop: pulse timeout_err, go to IDLE with no retire.
  - If eop and the timeout happen in the same cycle, eop wins.
- RETIRE: pulse retire. If fu_sel=BR and the captured br_taken=1, pulse redir_vld with redir_pc = captured target. Go to IDLE.
- eop is ignored outside WAIT. eop asserted during ISSUE is a protocol violation with no effect.
- Field outputs (opcode, funct3, pcdata_*, pc_cur) and fu_sel hold from DECODE until the next accept.
- br_taken is ignored for ALU and MEM units.

## Timing
- Reset values:
  - State: IDLE.
  - All pulses (fu_start, redir_vld, retire, ill_insn, timeout_err): 0.
  - fu_sel: 3.
  - Latched fields, pc_cur, redir_pc: 0.
  - opflag: 0.
  - ir_rdy: decoded from state, so it is 1 during and after reset.
- Handshake: transfer occurs on a rising edge with ir_vld & ir_rdy. ir_code and pc_in need only be valid in that cycle.
- All outputs except ir_rdy and opflag are registered.
- Latency, with accept at edge 0:
  - DECODE in cycle 1.
  - fu_start in cycle 2.
  - WAIT from cycle 3.
  - eop in WAIT cycle k (k≥3) → retire/redirect in cycle k+1 → IDLE in cycle k+2.
  - Minimum throughput: 5 cycles per instruction.
- Illegal instruction: ill_insn is visible in cycle 2, and ir_rdy returns high in cycle 2.
- Timeout: timeout_err is asserted in the cycle after the counter reaches TIMEOUT; ir_rdy is high that same cycle.
- Reset mid-operation returns the block to IDLE immediately. Any unit already started must be reset by the same rst_n.

## Structure
- Shared package kore_pkg contains:
  - Opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR).
  - fu_sel encodings FU_ALU, FU_MEM, FU_BR, FU_NONE.
  - The state encoding.
- Sub-module kore_dec_class: combinational, takes opcode and funct3, returns fu_sel and illegal. It is reusable by later decode stages.
- The top-level holds the FSM, field latches, wait counter and pulse registers.

## Test plan
- ADD x3,x1,x2 (0x002081B3) accepted with pc 0x100; eop in the first WAIT cycle → fu_sel=0, rs0=1, rs1=2, rd=3; fu_start in cycle 2; retire in cycle 4; no redir_vld.
- BEQ (0x00208463) at pc 0x200; eop with br_taken=1 and br_target=0x208 → fu_sel=2; redir_vld with redir_pc=0x208 in the retire cycle. Repeat with br_taken=0 → no redirect.
- Opcode 0x7F, then a branch with funct3=010 → ill_insn pulse in cycle 2 for each, no fu_start, ir_rdy high in cycle 2.
- LW with eop never asserted and TIMEOUT=4 → single timeout_err pulse, no retire, and the next instruction is accepted normally.
- Assert rst_n low while in WAIT → all outputs return to reset values asynchronously; after release, ir_rdy=1 and a fresh ADD completes in 5 cycles.
- Back-to-back instructions with ir_vld held high → each accept occurs only while in IDLE, and exactly one retire per accepted instruction.
